// File: rtl/bridge_pkg.sv
// Shared encodings for the CPU timer bridge: access sizes, register map,
// CTRL field positions and timer channel states.
package bridge_pkg;

    localparam logic [2:0] DM_NONE = 3'd0;
    localparam logic [2:0] DM_W    = 3'd1;
    localparam logic [2:0] DM_H    = 3'd2;
    localparam logic [2:0] DM_B    = 3'd3;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE    = 1;
    localparam int CTRL_IM      = 3;
    localparam int CTRL_PSC_LSB = 8;

    localparam logic [31:0] CTRL_MASK = 32'h0000_FF0B;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COUNT
    } chan_state_t;

endpackage

// File: rtl/timer_channel.sv
// One down-counting timer with prescaler, one-shot/auto-reload modes
// and a write-1-to-clear pending flag gated by an interrupt mask.
module timer_channel
    import bridge_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  sel,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    chan_state_t state, state_n;
    logic [31:0] ctrl, preset, count;
    logic [7:0]  psc_cnt;
    logic        pending;
    logic        ctrl_wr, preset_wr, status_wr, expire;

    assign ctrl_wr   = we && (sel == REG_CTRL);
    assign preset_wr = we && (sel == REG_PRESET);
    assign status_wr = we && (sel == REG_STATUS);
    assign expire    = (state == ST_COUNT) && (count == 32'd0);

    always_comb begin
        state_n = state;
        unique case (state)
            ST_LOAD:  state_n = ST_COUNT;
            ST_COUNT: if (expire)
                          state_n = (ctrl[CTRL_MODE] == MODE_RELOAD) ? ST_LOAD : ST_IDLE;
            default:  state_n = state;
        endcase
        // A CPU write to CTRL overrides whatever the counter wanted to do.
        if (ctrl_wr)
            state_n = wdata[CTRL_EN] ? ST_LOAD : ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            ctrl    <= '0;
            preset  <= '0;
            count   <= '0;
            psc_cnt <= '0;
            pending <= 1'b0;
        end else begin
            state <= state_n;
            if (ctrl_wr)
                ctrl <= wdata & CTRL_MASK;
            else if (expire && ctrl[CTRL_MODE] == MODE_ONESHOT)
                ctrl[CTRL_EN] <= 1'b0;
            if (preset_wr)
                preset <= wdata;
            if (state == ST_LOAD) begin
                count   <= preset;
                psc_cnt <= '0;
            end else if (state == ST_COUNT && !expire) begin
                if (psc_cnt == ctrl[CTRL_PSC_LSB +: 8]) begin
                    psc_cnt <= '0;
                    count   <= count - 32'd1;
                end else begin
                    psc_cnt <= psc_cnt + 8'd1;
                end
            end
            // Expiry wins over a same-edge clear.
            if (expire)
                pending <= 1'b1;
            else if (status_wr && wdata[0])
                pending <= 1'b0;
        end
    end

    always_comb begin
        rdata = '0;
        unique case (sel)
            REG_CTRL:   rdata = ctrl;
            REG_PRESET: rdata = preset;
            REG_COUNT:  rdata = count;
            REG_STATUS: rdata = {31'd0, pending};
        endcase
    end

    assign irq = pending & ctrl[CTRL_IM];

endmodule

// File: rtl/multi_timer_bridge.sv
// CPU data-memory bridge onto a bank of NUM_TIMERS timer channels:
// address decode, access legality, read mux and combined interrupt.
module multi_timer_bridge
    import bridge_pkg::*;
#(
    parameter int          NUM_TIMERS = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_7F00
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           addr,
    input  logic                  write_enable,
    input  logic [2:0]            dm_mode,
    input  logic [31:0]           write_data,
    input  logic                  stop,
    output logic [31:0]           read_result,
    output logic                  valid,
    output logic [NUM_TIMERS-1:0] irq,
    output logic                  irq_any
);

    localparam logic [31:0] WIN_SIZE = 32'(16 * NUM_TIMERS);

    logic [31:0] offset;
    logic [3:0]  ch;
    logic [1:0]  sel;
    logic        in_win, is_word, is_none, wr_ok;
    logic [31:0] rdata [NUM_TIMERS];

    assign offset  = addr - BASE_ADDR;
    assign in_win  = offset < WIN_SIZE;
    assign ch      = offset[7:4];
    assign sel     = addr[3:2];
    assign is_word = dm_mode == DM_W;
    assign is_none = dm_mode == DM_NONE;

    assign valid = is_none
                 | (in_win & is_word & (addr[1:0] == 2'b00)
                    & ~(write_enable & (sel == REG_COUNT)));

    assign wr_ok = valid & write_enable & ~stop & is_word & in_win;

    for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_ch
        timer_channel u_ch (
            .clk   (clk),
            .rst   (rst),
            .sel   (sel),
            .we    (wr_ok && (ch == 4'(i))),
            .wdata (write_data),
            .rdata (rdata[i]),
            .irq   (irq[i])
        );
    end

    always_comb begin
        read_result = '0;
        if (in_win && !is_none)
            for (int i = 0; i < NUM_TIMERS; i++)
                if (ch == 4'(i))
                    read_result = rdata[i];
    end

    assign irq_any = |irq;

endmodule

// File: tb/tb_multi_timer_bridge.sv
// Directed bench for multi_timer_bridge: vector table for decode/legality
// plus timed sequences for counting, modes, collisions and channel count.
module tb_multi_timer_bridge;
    import bridge_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_7F00;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic        write_enable;
    logic [2:0]  dm_mode;
    logic [31:0] write_data;
    logic        stop;

    logic [31:0] rd4, rd16, rd1;
    logic        v4, v16, v1;
    logic [3:0]  irq4;
    logic [15:0] irq16;
    logic [0:0]  irq1;
    logic        any4, any16, any1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    multi_timer_bridge #(.NUM_TIMERS(4), .BASE_ADDR(BASE)) u4 (
        .clk(clk), .rst(rst), .addr(addr), .write_enable(write_enable),
        .dm_mode(dm_mode), .write_data(write_data), .stop(stop),
        .read_result(rd4), .valid(v4), .irq(irq4), .irq_any(any4));

    multi_timer_bridge #(.NUM_TIMERS(16), .BASE_ADDR(BASE)) u16 (
        .clk(clk), .rst(rst), .addr(addr), .write_enable(write_enable),
        .dm_mode(dm_mode), .write_data(write_data), .stop(stop),
        .read_result(rd16), .valid(v16), .irq(irq16), .irq_any(any16));

    multi_timer_bridge #(.NUM_TIMERS(1), .BASE_ADDR(BASE)) u1 (
        .clk(clk), .rst(rst), .addr(addr), .write_enable(write_enable),
        .dm_mode(dm_mode), .write_data(write_data), .stop(stop),
        .read_result(rd1), .valid(v1), .irq(irq1), .irq_any(any1));

    typedef struct {
        logic [31:0] a;
        logic        we;
        logic [2:0]  dm;
        logic [31:0] wd;
        logic        st;
        logic        exp_valid;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        addr = '0; write_enable = 0; dm_mode = DM_NONE;
        write_data = '0; stop = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
        addr = a; write_enable = 1; dm_mode = DM_W; write_data = d; stop = 0;
        tick();
        idle();
    endtask

    task automatic cpu_read(input logic [31:0] a);
        addr = a; write_enable = 0; dm_mode = DM_W; write_data = '0; stop = 0;
        #1;
    endtask

    initial begin
        idle();
        rst = 1;
        tick(); tick();
        rst = 0;

        // reset state
        cpu_read(BASE);
        check("rst_ctrl0", rd4, 0);
        check("rst_irq", {27'd0, any4, irq4}, 0);

        // reset mid-count
        cpu_write(BASE + 32'h4, 10);
        cpu_write(BASE + 32'h0, 32'h9);
        repeat (5) tick();
        cpu_read(BASE + 32'h8);
        check("mid_count6", rd4, 6);
        idle();
        rst = 1;
        tick();
        rst = 0;
        cpu_read(BASE + 32'h8);
        check("rst_count", rd4, 0);
        cpu_read(BASE + 32'h0);
        check("rst_ctrl", rd4, 0);
        cpu_read(BASE + 32'h4);
        check("rst_preset", rd4, 0);
        check("rst_irq2", {27'd0, any4, irq4}, 0);

        // decode / legality table
        vecs.push_back('{BASE+32'h30, 1, DM_W,    32'hFFFF_FFF4, 0, 1, 32'h0});
        vecs.push_back('{BASE+32'h30, 0, DM_W,    32'h0,         0, 1, 32'h0000_FF00});
        vecs.push_back('{BASE+32'h34, 1, DM_W,    32'h1234_5678, 0, 1, 32'h0});
        vecs.push_back('{BASE+32'h34, 0, DM_W,    32'h0,         0, 1, 32'h1234_5678});
        vecs.push_back('{BASE+32'h38, 1, DM_W,    32'h5,         0, 0, 32'h0});
        vecs.push_back('{BASE+32'h38, 0, DM_W,    32'h0,         0, 1, 32'h0});
        vecs.push_back('{BASE+32'h18, 1, DM_W,    32'h7,         0, 0, 32'h0});
        vecs.push_back('{BASE+32'h36, 1, DM_W,    32'h0,         0, 0, 32'h1234_5678});
        vecs.push_back('{BASE+32'h02, 1, DM_W,    32'h9,         0, 0, 32'h0});
        vecs.push_back('{BASE+32'h00, 0, DM_W,    32'h0,         0, 1, 32'h0});
        vecs.push_back('{BASE+32'h34, 1, DM_H,    32'h0,         0, 0, 32'h1234_5678});
        vecs.push_back('{BASE+32'h34, 0, DM_W,    32'h0,         0, 1, 32'h1234_5678});
        vecs.push_back('{BASE+32'h40, 1, DM_W,    32'h0,         0, 0, 32'h0});
        vecs.push_back('{BASE+32'h34, 0, DM_NONE, 32'h0,         0, 1, 32'h0});
        vecs.push_back('{BASE+32'h34, 1, DM_W,    32'h0,         1, 1, 32'h1234_5678});
        vecs.push_back('{BASE+32'h34, 0, DM_W,    32'h0,         0, 1, 32'h1234_5678});
        vecs.push_back('{BASE+32'h3C, 1, DM_W,    32'h1,         0, 1, 32'h0});
        vecs.push_back('{BASE-32'h4,  0, DM_W,    32'h0,         0, 0, 32'h0});
        vecs.push_back('{BASE+32'h30, 0, DM_W,    32'h0,         0, 1, 32'h0000_FF00});
        foreach (vecs[i]) begin
            addr = vecs[i].a; write_enable = vecs[i].we; dm_mode = vecs[i].dm;
            write_data = vecs[i].wd; stop = vecs[i].st;
            #1;
            check($sformatf("vec%0d_valid", i), {31'd0, v4}, {31'd0, vecs[i].exp_valid});
            check($sformatf("vec%0d_rd", i), rd4, vecs[i].exp_rd);
            tick();
            idle();
        end

        // one-shot on ch1
        cpu_write(BASE + 32'h14, 3);
        cpu_write(BASE + 32'h10, 32'h9);
        repeat (4) tick();
        check("os_irq_early", {31'd0, irq4[1]}, 0);
        tick();
        check("os_irq_rise", {31'd0, irq4[1]}, 1);
        check("os_irq_any", {31'd0, any4}, 1);
        cpu_read(BASE + 32'h10);
        check("os_ctrl", rd4, 32'h8);
        cpu_read(BASE + 32'h18);
        check("os_count", rd4, 0);
        idle();
        repeat (3) tick();
        check("os_irq_hold", {31'd0, irq4[1]}, 1);
        cpu_write(BASE + 32'h1C, 32'h0);
        check("os_w1c_zero", {31'd0, irq4[1]}, 1);
        cpu_write(BASE + 32'h1C, 32'h1);
        check("os_irq_clr", {31'd0, irq4[1]}, 0);

        // auto-reload with prescaler on ch2
        cpu_write(BASE + 32'h24, 2);
        cpu_write(BASE + 32'h20, 32'h10B);
        for (int n = 1; n <= 18; n++) begin
            if (n == 7 || n == 13) begin
                addr = BASE + 32'h2C; write_enable = 1;
                dm_mode = DM_W; write_data = 1;
            end
            tick();
            idle();
            check($sformatf("ar_irq_n%0d", n), {31'd0, irq4[2]},
                  {31'd0, (n == 6 || n == 12 || n == 18)});
        end
        cpu_write(BASE + 32'h2C, 1);
        cpu_write(BASE + 32'h20, 32'h103);
        repeat (5) tick();
        cpu_read(BASE + 32'h2C);
        check("im0_pend_early", rd4, 0);
        idle();
        tick();
        cpu_read(BASE + 32'h2C);
        check("im0_pend", rd4, 1);
        check("im0_irq", {31'd0, irq4[2]}, 0);
        cpu_write(BASE + 32'h20, 0);
        cpu_write(BASE + 32'h2C, 1);

        // W1C on expiry edge of ch0
        cpu_write(BASE + 32'h4, 1);
        cpu_write(BASE + 32'h0, 32'h9);
        tick(); tick();
        cpu_write(BASE + 32'hC, 1);
        check("col_w1c_irq", {31'd0, irq4[0]}, 1);
        cpu_write(BASE + 32'hC, 1);
        check("col_w1c_clr", {31'd0, irq4[0]}, 0);

        // CTRL write on expiry edge of ch1
        cpu_write(BASE + 32'h14, 1);
        cpu_write(BASE + 32'h10, 32'h9);
        tick(); tick();
        cpu_write(BASE + 32'h10, 32'h9);
        check("col_ctrl_irq", {31'd0, irq4[1]}, 1);
        cpu_read(BASE + 32'h10);
        check("col_ctrl_en", rd4, 32'h9);
        idle();
        cpu_write(BASE + 32'h10, 0);
        cpu_write(BASE + 32'h1C, 1);

        // stop blocks writes while counting continues
        cpu_write(BASE + 32'h4, 20);
        cpu_write(BASE + 32'h0, 32'h1);
        repeat (3) tick();
        addr = BASE + 32'h4; write_enable = 1; dm_mode = DM_W;
        write_data = 0; stop = 1;
        #1;
        check("stop_valid", {31'd0, v4}, 1);
        tick();
        idle();
        cpu_read(BASE + 32'h4);
        check("stop_preset", rd4, 20);
        cpu_read(BASE + 32'h8);
        check("stop_count17", rd4, 17);
        addr = BASE; write_enable = 1; dm_mode = DM_W;
        write_data = 0; stop = 1;
        tick();
        idle();
        cpu_read(BASE);
        check("stop_ctrl", rd4, 32'h1);
        cpu_read(BASE + 32'h8);
        check("stop_count16", rd4, 16);

        // channel-count sweep
        cpu_write(BASE + 32'hF4, 32'hABCD);
        cpu_read(BASE + 32'hF4);
        check("n16_top_rd", rd16, 32'hABCD);
        check("n16_top_valid", {31'd0, v16}, 1);
        check("n4_f4_valid", {31'd0, v4}, 0);
        check("n4_f4_rd", rd4, 0);
        cpu_read(BASE + 32'h100);
        check("n16_past_valid", {31'd0, v16}, 0);
        check("n16_past_rd", rd16, 0);
        cpu_read(BASE + 32'h10);
        check("n1_past_valid", {31'd0, v1}, 0);
        check("n1_past_rd", rd1, 0);
        cpu_read(BASE + 32'h4);
        check("n1_ch0_valid", {31'd0, v1}, 1);
        check("n1_ch0_rd", rd1, 20);
        check("any4_or", {31'd0, any4}, {31'd0, |irq4});
        check("any16_or", {31'd0, any16}, {31'd0, |irq16});
        check("any1_or", {31'd0, any1}, {31'd0, irq1[0]});
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
